// File: rtl/div64by32.sv
`default_nettype none
// ============================================================================
// Module   : div64by32
// Purpose  : Multi-cycle unsigned divider. It divides a 2*DW-bit dividend by
//            a DW-bit divisor and produces a DW-bit quotient and a DW-bit
//            remainder using a restoring algorithm. Radix-2 retires one
//            quotient bit per cycle. With DIV_RADIX4_EN defined, radix-4
//            retires two bits per cycle.
//            Overflow and divide-by-zero cases bypass the iteration and
//            finish in a single cycle.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            in_valid/in_ready   operand handshake (accept when both high)
//            dividend, divisor   operands, sampled on accept
//            out_valid/out_ready result handshake
//            quotient, remainder result, held until handoff
//            overflow            quotient would not fit in DW bits
//            div_by_zero         divisor was zero
// Macro    : DIV_RADIX4_EN - two restoring steps per CALC cycle (DW even)
// Revision : 1.0 - initial release
// ============================================================================
module div64by32 #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            overflow,
  output logic            div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef DIV_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam int            CW     = $clog2(DW + 1);
  localparam logic [CW-1:0] C_STEP = CW'(STEP);
  // The counter holds the number of bits already retired. The final CALC
  // cycle is the one that starts with DW-STEP bits done.
  localparam logic [CW-1:0] C_LAST = CW'(DW - STEP);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] q_q, q_d;
  logic [DW-1:0] divisor_q, divisor_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [DW-1:0] remainder_q, remainder_d;
  logic          overflow_q, overflow_d;
  logic          div_by_zero_q, div_by_zero_d;

  // One restoring step. The result is {rem_next, q_next}. Entering CALC
  // requires rem < divisor, so t < 2*divisor. The subtraction therefore
  // always lands below divisor, and only its low DW bits are needed.
  function automatic logic [2*DW-1:0] restore_step(
    input logic [DW-1:0] rem,
    input logic [DW-1:0] q,
    input logic [DW-1:0] d
  );
    logic [DW:0]   t;
    logic [DW-1:0] rem_n;
    logic          bit_n;
    t = {rem, q[DW-1]};
    if (t >= {1'b0, d}) begin
      rem_n = t[DW-1:0] - d;
      bit_n = 1'b1;
    end else begin
      rem_n = t[DW-1:0];
      bit_n = 1'b0;
    end
    return {rem_n, q[DW-2:0], bit_n};
  endfunction

  logic [2*DW-1:0] step1;
  logic [2*DW-1:0] step_out;

  assign step1 = restore_step(rem_q, q_q, divisor_q);
`ifdef DIV_RADIX4_EN
  assign step_out = restore_step(step1[2*DW-1:DW], step1[DW-1:0], divisor_q);
`else
  assign step_out = step1;
`endif

  logic [DW-1:0] dvd_hi;
  logic [DW-1:0] dvd_lo;
  assign dvd_hi = dividend[2*DW-1:DW];
  assign dvd_lo = dividend[DW-1:0];

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    q_d           = q_q;
    divisor_d     = divisor_q;
    cnt_d         = cnt_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    overflow_d    = overflow_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d     = dvd_hi;
          q_d       = dvd_lo;
          divisor_d = divisor;
          cnt_d     = '0;
          // A zero divisor always satisfies hi >= divisor, so it takes the
          // overflow path as well.
          if (dvd_hi >= divisor) begin
            state_d       = DONE;
            quotient_d    = '1;
            remainder_d   = dvd_lo;
            overflow_d    = 1'b1;
            div_by_zero_d = (divisor == '0);
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_out[2*DW-1:DW];
        q_d   = step_out[DW-1:0];
        cnt_d = cnt_q + C_STEP;
        if (cnt_q == C_LAST) begin
          state_d       = DONE;
          quotient_d    = step_out[DW-1:0];
          remainder_d   = step_out[2*DW-1:DW];
          overflow_d    = 1'b0;
          div_by_zero_d = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      q_q           <= '0;
      divisor_q     <= '0;
      cnt_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      q_q           <= q_d;
      divisor_q     <= divisor_d;
      cnt_q         <= cnt_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      overflow_q    <= overflow_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  // The handshake flags decode directly from the state. Reset therefore
  // takes effect on them immediately, without waiting for a clock edge.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_div64by32.sv
`default_nettype none
// ============================================================================
// Module   : tb_div64by32
// Purpose  : Self-checking bench for div64by32 (DW=32). Each expected result
//            is pushed to a scoreboard queue when its operands are driven.
//            The entry is popped and compared when out_valid appears.
//            Honours DIV_RADIX4_EN for the expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div64by32;

`ifdef DIV_RADIX4_EN
  localparam int LAT_N = 17;
`else
  localparam int LAT_N = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  div64by32 #(.DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        ovf;
    logic        dbz;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] q, input logic [31:0] r,
                          input logic ovf, input logic dbz, input int lat);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.ovf = ovf;
    e.dbz = dbz;
    e.lat = 8'(lat);
    sb.push_back(e);
  endtask

  // Reference model built from native 64-bit arithmetic.
  task automatic push_model(input logic [63:0] dd, input logic [31:0] dv);
    if (dv == 32'd0 || dd[63:32] >= dv)
      push_exp(32'hFFFF_FFFF, dd[31:0], 1'b1, (dv == 32'd0), 1);
    else
      push_exp(32'(dd / {32'd0, dv}), 32'(dd % {32'd0, dv}), 1'b0, 1'b0, LAT_N);
  endtask

  // Drive the operands and let the accept edge pass. On return, simulation
  // sits 1 time unit after the accepting edge, with scrambled operands.
  task automatic issue(input logic [63:0] dd, input logic [31:0] dv);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
  endtask

  // Latency counts edges from the accepting edge (edge 1) up to the edge
  // after which out_valid is seen.
  task automatic compare_result();
    int   lat;
    exp_t e;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      if (!out_valid) begin
        check("timeout", 64'(out_valid), 64'd1);
      end else begin
        check("latency",     64'(lat),         64'(e.lat));
        check("quotient",    64'(quotient),    64'(e.q));
        check("remainder",   64'(remainder),   64'(e.r));
        check("overflow",    64'(overflow),    64'(e.ovf));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
      end
    end
  endtask

  task automatic handoff();
    @(posedge clk);
    #1;
    check("handoff_valid", 64'(out_valid), 64'd0);
    check("handoff_ready", 64'(in_ready),  64'd1);
  endtask

  task automatic run(input logic [63:0] dd, input logic [31:0] dv);
    push_model(dd, dv);
    issue(dd, dv);
    compare_result();
    handoff();
  endtask

  initial begin
    logic [31:0] a, b, r;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),    64'd1);
    check("rst_out_valid", 64'(out_valid),   64'd0);
    check("rst_quotient",  64'(quotient),    64'd0);
    check("rst_remainder", 64'(remainder),   64'd0);
    check("rst_overflow",  64'(overflow),    64'd0);
    check("rst_dbz",       64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    // Directed cases
    run(64'd100, 32'd3);
    run(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    run(64'h1234_5678_9ABC_DEF0, 32'd0);
    run(64'h0000_0005_0000_0007, 32'd5);
    run(64'h0000_0004_FFFF_FFFF, 32'd5);

    // Backpressure: result held while new operands are presented
    out_ready = 1'b0;
    push_model(64'd100, 32'd3);
    issue(64'd100, 32'd3);
    compare_result();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = {$urandom, $urandom};
      divisor  = $urandom;
      @(posedge clk);
      #1;
      check("bp_valid",     64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_quotient",  64'(quotient),  64'd33);
      check("bp_remainder", 64'(remainder), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    dividend  = 64'h0000_0005_0000_0007;
    divisor   = 32'd5;
    push_model(64'h0000_0005_0000_0007, 32'd5);
    @(posedge clk);
    #1;
    check("bp_no_accept_valid", 64'(out_valid), 64'd0);
    check("bp_no_accept_ready", 64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    compare_result();
    handoff();

    // Product inverse: dividend = A*B + R with R < B
    for (int i = 0; i < 200; i++) begin
      do b = $urandom; while (b == 32'd0);
      a = $urandom;
      r = $urandom % b;
      push_exp(a, r, 1'b0, 1'b0, LAT_N);
      issue({32'd0, a} * {32'd0, b} + {32'd0, r}, b);
      compare_result();
      handoff();
    end

    // Reset in the middle of CALC
    push_model(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_quotient",  64'(quotient),  64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(64'd100, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
